decode_stage: RTL
=================

# decode_stage

Decode/issue stage of the single-issue CPU. Sits directly upstream of the ALU. Accepts 32-bit RV32I instructions over a valid/ready handshake and decodes ADDI/XORI/ORI/ANDI/LUI. Reads operands from an internal 32×32 register file that is written back from the ALU result path, and presents `src_a`, `src_b`, `op` and `rd` to the ALU through a registered valid/ready output. A scoreboard stalls read-after-write hazards, and the stage halts permanently on an illegal instruction.

## Interface
- `NREGS`, default 32: register count. Fixed at 32. Register x0 reads as zero.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `instr` is valid.
- `in_ready` output, 1 bit: the stage accepts `instr` this cycle.
- `instr` input, 32 bits: RV32I instruction word.
- `out_valid` output, 1 bit: the ALU operands are valid.
- `out_ready` input, 1 bit: the downstream stage takes the operands this cycle.
- `src_a` output, 32 bits: ALU operand A.
- `src_b` output, 32 bits: ALU operand B.
- `op` output, 3 bits: ALU operation code.
  - 000 = pass A
  - 001 = add
  - 010 = xor
  - 011 = or
  - 100 = and
- `rd` output, 5 bits: destination register carried alongside the operands.
- `wb_en` input, 1 bit: writeback strobe.
- `wb_rd` input, 5 bits: writeback register index.
- `wb_data` input, 32 bits: writeback value.
- `illegal` output, 1 bit: sticky. Set when an unsupported instruction is accepted.

## Operation
**Handshake**
- Accept condition: `in_valid && in_ready`.
- `in_ready` = !halted && (!out_valid || out_ready) && !hazard.
- The output register loads on accept.
- `out_valid` clears on `out_ready` when no new accept occurs in the same cycle.
- `src_a`, `src_b`, `op` and `rd` stay stable while `out_valid && !out_ready`.

**Decode** (opcode = `instr[6:0]`, funct3 = `instr[14:12]`, rs1 = `instr[19:15]`)
- Opcode 0010011:
  - funct3 000 → op 001 (ADDI)
  - funct3 100 → op 010 (XORI)
  - funct3 110 → op 011 (ORI)
  - funct3 111 → op 100 (ANDI)
- For these four: `src_a` = R[rs1]; `src_b` = sign-extended `instr[31:20]`.
- Opcode 0110111 (LUI): op 000; `src_a` = {`instr[31:12]`, 12'b0}; `src_b` = 0; no rs1 read.
- Any other opcode/funct3 combination is illegal.

**Register file and writeback**
- Written when `wb_en && wb_rd != 0`. Writes to x0 are dropped.
- Read forwarding: if `wb_en && wb_rd == rs1 && rs1 != 0` in the accept cycle, `src_a` = `wb_data`.

**Scoreboard** (32 pending bits; bit 0 is always 0)
- Accept with rd != 0 sets pending[rd].
- `wb_en` clears pending[wb_rd].
- Same register set and cleared in one cycle: set wins.
- hazard = opcode uses rs1 && pending[rs1] && !(`wb_en && wb_rd == rs1`).
- Writebacks are in order; at most one writeback per cycle.

**State machine** (RUN, HALT)
- RUN → HALT when an illegal instruction is accepted.
  - That instruction is consumed but not forwarded. `out_valid` does not set for it.
  - `illegal` goes to 1 and stays there.
- HALT: `in_ready` = 0. The output register drains normally. Writeback and scoreboard keep operating.
- Only `rst_n` leaves HALT.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction/cycle when there is no hazard and `out_ready` = 1.
- Reset (asynchronous, takes effect immediately): all 32 registers = 0, pending = 0, state = RUN.
  - `out_valid` = 0, `src_a` = `src_b` = 0, `op` = 000, `rd` = 0, `illegal` = 0.
  - `in_ready` rises in the first cycle after `rst_n` deasserts.
- Reset mid-transfer discards the held output and all pending bits.
- Back-to-back dependent instructions (the second reads the first's rd) stall until the writeback cycle. They may issue in that same cycle via forwarding.
- `in_ready` may depend combinationally on `out_ready`, `instr` and the `wb_*` inputs. There is no path from `in_valid` to `in_ready`.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream.
  - Required: `out_valid`/`illegal` = 0 immediately.
  - Required: after release, ADDI x1,x1,0 yields `src_a` = 0.
- **ADDI decode:** ADDI x1,x0,-5 (0xFFB00093).
  - Required: one cycle later `op` = 001, `src_a` = 0, `src_b` = 0xFFFFFFFB, `rd` = 1.
- **Forwarding:** writeback x1 = 0x10, then XORI x2,x1,0x0F.
  - Required: `src_a` = 0x10, `src_b` = 0xF.
  - Repeat with `wb_en` in the same cycle as the accept → same `src_a`, no stall.
- **Hazard stall:** issue ADDI x3,x0,1, then ORI x4,x3,2.
  - Required: `in_ready` = 0 until `wb_rd` = 3 is strobed.
  - Required: the second instruction issues in that cycle with `src_a` = `wb_data`.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles after LUI x5,0x12345.
  - Required: `src_a` holds 0x12345000 with `op` = 000; `in_ready` = 0.
  - Required: the next instruction is accepted in the cycle `out_ready` returns.
- **Illegal:** accept 0x00000000.
  - Required: `illegal` = 1 the next cycle; `out_valid` is not set for it; `in_ready` stays 0.
  - Required: a pending writeback still updates the register file and clears the scoreboard.

Source files
------------

// File: rtl/decode_stage.sv
// Decode/issue stage: RV32I OP-IMM/LUI decode, register file,
// RAW scoreboard and sticky halt on illegal instructions.
module decode_stage #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] src_a,
  output logic [31:0] src_b,
  output logic [2:0]  op,
  output logic [4:0]  rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        illegal
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t r_state, w_state_nxt;
  logic   w_halted;

  logic [31:0] r_regs [NREGS];
  logic [NREGS-1:0] r_pend, w_pend_nxt;

  logic        r_ov;
  logic [31:0] r_a, r_b;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rdi;
  logic        w_legal, w_use_rs1, w_lui;
  logic [2:0]  w_op;
  logic        w_fwd, w_hazard, w_acc, w_issue;
  logic [31:0] w_rs1_val, w_a, w_b;

  assign w_opc = instr[6:0];
  assign w_f3  = instr[14:12];
  assign w_rs1 = instr[19:15];
  assign w_rdi = instr[11:7];

  always_comb begin
    w_legal   = 1'b0;
    w_use_rs1 = 1'b0;
    w_lui     = 1'b0;
    w_op      = 3'b000;
    unique case (1'b1)
      (w_opc == 7'b0010011 && w_f3 == 3'b000): begin
        w_legal = 1'b1; w_use_rs1 = 1'b1; w_op = 3'b001;
      end
      (w_opc == 7'b0010011 && w_f3 == 3'b100): begin
        w_legal = 1'b1; w_use_rs1 = 1'b1; w_op = 3'b010;
      end
      (w_opc == 7'b0010011 && w_f3 == 3'b110): begin
        w_legal = 1'b1; w_use_rs1 = 1'b1; w_op = 3'b011;
      end
      (w_opc == 7'b0010011 && w_f3 == 3'b111): begin
        w_legal = 1'b1; w_use_rs1 = 1'b1; w_op = 3'b100;
      end
      (w_opc == 7'b0110111): begin
        w_legal = 1'b1; w_lui = 1'b1;
      end
      default: ;
    endcase
  end

  // A same-cycle writeback both forwards and resolves the hazard
  assign w_fwd = wb_en && (wb_rd == w_rs1);
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 :
                     w_fwd ? wb_data : r_regs[w_rs1];
  assign w_a = w_lui ? {instr[31:12], 12'b0} : w_rs1_val;
  assign w_b = w_lui ? 32'd0 : {{20{instr[31]}}, instr[31:20]};

  assign w_hazard = w_use_rs1 && r_pend[w_rs1] && !w_fwd;
  assign in_ready = rst_n && !w_halted &&
                    (!r_ov || out_ready) && !w_hazard;
  assign w_acc   = in_valid && in_ready;
  assign w_issue = w_acc && w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_RUN && w_acc && !w_legal)
      w_state_nxt = S_HALT;
  end

  always_comb begin
    w_halted = (r_state == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    w_pend_nxt = r_pend;
    if (wb_en) w_pend_nxt[wb_rd] = 1'b0;
    if (w_issue && w_rdi != 5'd0) w_pend_nxt[w_rdi] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
      r_rd <= '0;
    end else if (w_issue) begin
      r_ov <= 1'b1;
      r_a  <= w_a;
      r_b  <= w_b;
      r_op <= w_op;
      r_rd <= w_rdi;
    end else if (out_ready) begin
      r_ov <= 1'b0;
    end
  end

  assign out_valid = r_ov;
  assign src_a     = r_a;
  assign src_b     = r_b;
  assign op        = r_op;
  assign rd        = r_rd;
  assign illegal   = w_halted;

endmodule
